// File: rtl/test_status_pkg.sv
// Shared types and defaults for the test_status run tracker.
package test_status_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int          DEF_CNT_W       = 16;
    localparam logic [23:0] DEF_TIMEOUT_CYC = 24'd10000000;

endpackage

// File: rtl/stall_watchdog.sv
// Counts consecutive RUN cycles without a transfer; expired flags the cycle
// in which the stall reaches TIMEOUT_CYC.
module stall_watchdog #(
    parameter logic [23:0] TIMEOUT_CYC = 24'd10000000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic kick,
    output logic expired
);

    logic [23:0] cnt_q;
    logic [23:0] cnt_d;

    assign expired = run & ~kick & (cnt_q == (TIMEOUT_CYC - 24'd1));

    // Next stall count: cleared outside RUN or on a transfer, held once expired
    always_comb begin
        cnt_d = cnt_q;
        if (!run || kick) begin
            cnt_d = 24'd0;
        end else if (expired) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 24'd1;
        end
    end

    // Stall counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 24'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/test_status.sv
// Test/compare run tracker: counts comparator results, reports done/pass.
// Optional stall watchdog enabled by defining STATUS_TIMEOUT_EN.
module test_status
    import test_status_pkg::*;
#(
    parameter int          CNT_W       = DEF_CNT_W,
    parameter logic [23:0] TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] exp_count,
    input  logic             cmp_valid,
    input  logic             cmp_match,
    output logic             cmp_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONES = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q,   state_d;
    logic [CNT_W-1:0] vec_q,     vec_d;
    logic [CNT_W-1:0] err_q,     err_d;
    logic [CNT_W-1:0] exp_q,     exp_d;
    logic             done_q,    done_d;
    logic             pass_q,    pass_d;
    logic             timeout_q, timeout_d;

    logic             run_s;
    logic             xfer_s;
    logic             wd_expired_s;
    logic [CNT_W-1:0] vec_inc_s;
    logic [CNT_W-1:0] err_next_s;

    assign run_s      = (state_q == ST_RUN);
    assign xfer_s     = cmp_valid & run_s;
    assign vec_inc_s  = vec_q + CNT_ONE;
    assign err_next_s = (!cmp_match && (err_q != CNT_ONES)) ? (err_q + CNT_ONE) : err_q;

`ifdef STATUS_TIMEOUT_EN
    stall_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_stall_watchdog (
        .clk     (clk),
        .reset   (reset),
        .run     (run_s),
        .kick    (xfer_s),
        .expired (wd_expired_s)
    );
`else
    // No watchdog in this build; the parameter is referenced only to keep the interface uniform.
    assign wd_expired_s = 1'b0 & (|TIMEOUT_CYC);
`endif

    // Next-state and counter update logic
    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        err_d     = err_q;
        exp_d     = exp_q;
        done_d    = done_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    vec_d     = CNT_ZERO;
                    err_d     = CNT_ZERO;
                    exp_d     = exp_count;
                    timeout_d = 1'b0;
                    if (exp_count == CNT_ZERO) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        done_d  = 1'b0;
                        pass_d  = 1'b0;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (xfer_s) begin
                    vec_d = vec_inc_s;
                    err_d = err_next_s;
                    if (vec_inc_s == exp_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        pass_d  = (err_next_s == CNT_ZERO) & ~timeout_q;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (wd_expired_s) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    pass_d    = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                done_d  = 1'b0;
                pass_d  = 1'b0;
            end
        endcase
    end

    // State, counters and status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            vec_q     <= CNT_ZERO;
            err_q     <= CNT_ZERO;
            exp_q     <= CNT_ZERO;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            err_q     <= err_d;
            exp_q     <= exp_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
        end
    end

    assign cmp_ready = run_s;
    assign busy      = run_s;
    assign done      = done_q;
    assign pass      = pass_q;
    assign timeout   = timeout_q;
    assign vec_count = vec_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_test_status.sv
// Scoreboard bench for test_status; expectations for the watchdog scenario
// follow whether STATUS_TIMEOUT_EN is defined.
module tb_test_status;

    localparam int CW = 16;
    localparam int TO = 100;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [CW-1:0] exp_count;
    logic          cmp_valid;
    logic          cmp_match;
    logic          cmp_ready;
    logic          busy;
    logic          done;
    logic          pass;
    logic [CW-1:0] vec_count;
    logic [CW-1:0] err_count;
    logic          timeout;

    typedef struct packed {
        logic [CW-1:0] vec;
        logic [CW-1:0] err;
        logic          pass;
        logic          to;
    } res_t;

    res_t sb_q[$];
    logic done_prev = 1'b0;
    int   n_checks  = 0;
    int   n_fail    = 0;

    test_status #(
        .CNT_W       (CW),
        .TIMEOUT_CYC (24'd100)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .exp_count (exp_count),
        .cmp_valid (cmp_valid),
        .cmp_match (cmp_match),
        .cmp_ready (cmp_ready),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .vec_count (vec_count),
        .err_count (err_count),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // Scoreboard: every rising edge of done must match the oldest queued expectation
    always @(negedge clk) begin : sb_mon
        res_t e;
        if (done === 1'b1 && done_prev !== 1'b1) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_done: done rose with vec=%0d err=%0d, none expected", vec_count, err_count);
            end else begin
                e = sb_q.pop_front();
                n_checks++;
                if (vec_count !== e.vec) begin n_fail++; $display("FAIL sb_vec: got %0d want %0d", vec_count, e.vec); end
                n_checks++;
                if (err_count !== e.err) begin n_fail++; $display("FAIL sb_err: got %0d want %0d", err_count, e.err); end
                n_checks++;
                if (pass !== e.pass) begin n_fail++; $display("FAIL sb_pass: got %b want %b", pass, e.pass); end
                n_checks++;
                if (timeout !== e.to) begin n_fail++; $display("FAIL sb_timeout: got %b want %b", timeout, e.to); end
            end
        end
        done_prev = done;
    end

    initial begin
        #100000;
        $display("FAIL global_time_limit: bench did not complete");
        $fatal(1, "time limit");
    end

    // Called at a negedge; start is held across exactly one rising edge
    task automatic do_start(input logic [CW-1:0] n);
        start     = 1'b1;
        exp_count = n;
        @(negedge clk);
        start     = 1'b0;
        exp_count = 16'hDEAD;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic send(input logic m);
        int n;
        n         = 0;
        cmp_valid = 1'b1;
        cmp_match = m;
        while (cmp_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (cmp_ready !== 1'b1) begin n_fail++; $display("FAIL send_ready_wait: cmp_ready=%b after %0d cycles, want 1", cmp_ready, n); end
        @(negedge clk);
        cmp_valid = 1'b0;
        cmp_match = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; cmp_valid = 1'b0; cmp_match = 1'b0; exp_count = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({cmp_ready, busy, done, pass, timeout} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 00000", {cmp_ready, busy, done, pass, timeout}); end
        n_checks++;
        if ({vec_count, err_count} !== 32'd0) begin n_fail++; $display("FAIL reset_counts: vec=%0d err=%0d want 0", vec_count, err_count); end
        reset = 1'b0; cmp_valid = 1'b1; cmp_match = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({cmp_ready, busy} !== 2'b0) begin n_fail++; $display("FAIL idle_no_accept_ready: got %b want 00", {cmp_ready, busy}); end
        n_checks++;
        if ({vec_count, err_count} !== 32'd0) begin n_fail++; $display("FAIL idle_no_accept_cnt: vec=%0d err=%0d want 0", vec_count, err_count); end
        cmp_valid = 1'b0;
    endtask

    task automatic test_basic4();
        sb_q.push_back('{16'd4, 16'd0, 1'b1, 1'b0});
        do_start(16'd4);
        n_checks++;
        if ({busy, cmp_ready, done} !== 3'b110) begin n_fail++; $display("FAIL basic_run_state: busy/ready/done=%b want 110", {busy, cmp_ready, done}); end
        for (int i = 0; i < 3; i++) send(1'b1);
        n_checks++;
        if (done !== 1'b0 || vec_count !== 16'd3) begin n_fail++; $display("FAIL basic_mid: done=%b vec=%0d want 0/3", done, vec_count); end
        send(1'b1);
        n_checks++;
        if ({done, pass, busy, cmp_ready} !== 4'b1100) begin n_fail++; $display("FAIL basic_done_latency: done/pass/busy/ready=%b want 1100", {done, pass, busy, cmp_ready}); end
    endtask

    task automatic test_gapped5();
        sb_q.push_back('{16'd5, 16'd2, 1'b0, 1'b0});
        do_start(16'd5);
        for (int i = 1; i <= 5; i++) begin
            send(!(i == 2 || i == 4));
            if (i < 5) repeat (2) @(negedge clk);
        end
        n_checks++;
        if ({done, pass} !== 2'b10 || err_count !== 16'd2) begin n_fail++; $display("FAIL gapped_end: done/pass=%b err=%0d want 10/2", {done, pass}, err_count); end
    endtask

    task automatic test_restart();
        n_checks++;
        if ({done, pass} !== 2'b10) begin n_fail++; $display("FAIL restart_pre: done/pass=%b want 10", {done, pass}); end
        sb_q.push_back('{16'd2, 16'd0, 1'b1, 1'b0});
        do_start(16'd2);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b1 || vec_count !== 16'd0 || err_count !== 16'd0) begin
            n_fail++; $display("FAIL restart_clear: done=%b busy=%b vec=%0d err=%0d want 0/1/0/0", done, busy, vec_count, err_count);
        end
        send(1'b1);
        send(1'b1);
        n_checks++;
        if ({done, pass} !== 2'b11) begin n_fail++; $display("FAIL restart_end: done/pass=%b want 11", {done, pass}); end
    endtask

    task automatic test_zero();
        pulse_reset();
        sb_q.push_back('{16'd0, 16'd0, 1'b1, 1'b0});
        n_checks++;
        if (cmp_ready !== 1'b0) begin n_fail++; $display("FAIL zero_ready_pre: got %b want 0", cmp_ready); end
        do_start(16'd0);
        n_checks++;
        if ({done, pass, cmp_ready, busy} !== 4'b1100 || vec_count !== 16'd0) begin
            n_fail++; $display("FAIL zero_done: done/pass/ready/busy=%b vec=%0d want 1100/0", {done, pass, cmp_ready, busy}, vec_count);
        end
        cmp_valid = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (cmp_ready !== 1'b0 || vec_count !== 16'd0 || done !== 1'b1) begin
            n_fail++; $display("FAIL zero_hold: ready=%b vec=%0d done=%b want 0/0/1", cmp_ready, vec_count, done);
        end
        cmp_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        sb_q.push_back('{16'd3, 16'd1, 1'b0, 1'b0});
        do_start(16'd3);
        send(1'b1);
        start = 1'b1; exp_count = 16'd7;
        send(1'b0);
        start = 1'b0; exp_count = 16'hDEAD;
        send(1'b1);
        n_checks++;
        if (done !== 1'b1 || vec_count !== 16'd3 || err_count !== 16'd1) begin
            n_fail++; $display("FAIL b2b_start_ignored: done=%b vec=%0d err=%0d want 1/3/1", done, vec_count, err_count);
        end
    endtask

    task automatic test_timeout();
`ifdef STATUS_TIMEOUT_EN
        sb_q.push_back('{16'd1, 16'd0, 1'b0, 1'b1});
`endif
        do_start(16'd3);
        send(1'b1);
        repeat (TO - 1) @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL timeout_early: done=%b busy=%b want 0/1", done, busy); end
        @(negedge clk);
`ifdef STATUS_TIMEOUT_EN
        n_checks++;
        if ({done, timeout, pass, busy} !== 4'b1100 || vec_count !== 16'd1) begin
            n_fail++; $display("FAIL timeout_fire: done/to/pass/busy=%b vec=%0d want 1100/1", {done, timeout, pass, busy}, vec_count);
        end
`else
        repeat (20) @(negedge clk);
        n_checks++;
        if ({done, timeout, busy, cmp_ready} !== 4'b0011) begin
            n_fail++; $display("FAIL no_watchdog_wait: done/to/busy/ready=%b want 0011", {done, timeout, busy, cmp_ready});
        end
`endif
        pulse_reset();
    endtask

    task automatic test_mid_reset();
        do_start(16'd8);
        for (int i = 0; i < 3; i++) send(1'b1);
        n_checks++;
        if (vec_count !== 16'd3) begin n_fail++; $display("FAIL midrst_pre: vec=%0d want 3", vec_count); end
        cmp_valid = 1'b1; cmp_match = 1'b0;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({cmp_ready, busy, done, pass, timeout} !== 5'b0 || {vec_count, err_count} !== 32'd0) begin
            n_fail++; $display("FAIL midrst_async: flags=%b vec=%0d err=%0d want 0", {cmp_ready, busy, done, pass, timeout}, vec_count, err_count);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({cmp_ready, busy} !== 2'b0 || vec_count !== 16'd0) begin
            n_fail++; $display("FAIL midrst_idle: ready/busy=%b vec=%0d want 00/0", {cmp_ready, busy}, vec_count);
        end
        sb_q.push_back('{16'd1, 16'd0, 1'b1, 1'b0});
        cmp_match = 1'b1;
        do_start(16'd1);
        @(negedge clk);
        cmp_valid = 1'b0;
        n_checks++;
        if (done !== 1'b1 || vec_count !== 16'd1) begin n_fail++; $display("FAIL midrst_resume: done=%b vec=%0d want 1/1", done, vec_count); end
    endtask

    initial begin
        test_reset();
        test_basic4();
        test_gapped5();
        test_restart();
        test_zero();
        test_back_to_back();
        test_timeout();
        test_mid_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover: %0d expected results never produced, want 0", sb_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
